lcd_bus_scheduler: RTL and testbench

//  Owns the character-LCD bus of the digital watch. Runs the power-on init sequence,

---
 rtl/lcd_bus_scheduler.sv | 165 ++++++++++++++++
 tb/tb_lcd_bus_scheduler.sv | 296 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/lcd_bus_scheduler.sv
// HD44780 write-bus owner: runs the power-on init ROM, then arbitrates two requesters onto the LCD.
// Define LCD_FIXED_PRIO_EN to make requester 0 always win ties instead of round-robin.
module lcd_bus_scheduler #(
   parameter int unsigned INIT_WAIT_CYC = 15000,
   parameter int unsigned SETUP_CYC     = 1,
   parameter int unsigned E_HIGH_CYC    = 2,
   parameter int unsigned HOLD_CYC      = 40,
   parameter int unsigned CLR_WAIT_CYC  = 1600
) (
   input  logic       CLK_1M,
   input  logic       RESET,
   input  logic [1:0] REQ,
   input  logic [1:0] REQ_RS,
   input  logic [7:0] REQ_DATA0,
   input  logic [7:0] REQ_DATA1,
   output logic [1:0] GNT,
   output logic       BUSY,
   output logic       INIT_DONE,
   output logic       LCD_E,
   output logic       LCD_RS,
   output logic       LCD_RW,
   output logic [7:0] LCD_DATA
);

   typedef enum logic [2:0] {
      S_INIT_WAIT,
      S_INIT_SEND,
      S_SETUP,
      S_E_HIGH,
      S_HOLD,
      S_IDLE
   } state_t;

   localparam logic [15:0] INIT_LAST  = 16'(INIT_WAIT_CYC - 1);
   localparam logic [15:0] SETUP_LAST = 16'(SETUP_CYC - 1);
   localparam logic [15:0] E_LAST     = 16'(E_HIGH_CYC - 1);
   localparam logic [15:0] HOLD_LAST  = 16'(HOLD_CYC - 1);
   localparam logic [15:0] CLR_LAST   = 16'(CLR_WAIT_CYC - 1);

   state_t      state_q, state_d;
   logic [15:0] cnt_q, cnt_d;
   logic [1:0]  idx_q, idx_d;
   logic        init_done_q, init_done_d;
   logic        rr_last_q, rr_last_d;
   logic        rs_q, rs_d;
   logic [7:0]  data_q, data_d;
   logic        win_valid;
   logic        win_sel;
   logic [15:0] hold_last;

   function automatic logic [7:0] init_rom(input logic [1:0] idx);
      case (idx)
         2'd0:    return 8'h38;
         2'd1:    return 8'h0C;
         2'd2:    return 8'h06;
         default: return 8'h01;
      endcase
   endfunction

   // Clear and home need the long post-strobe wait.
   assign hold_last = (!rs_q && (data_q == 8'h01 || data_q == 8'h02)) ? CLR_LAST : HOLD_LAST;

   always_comb begin
      win_valid = |REQ;
`ifdef LCD_FIXED_PRIO_EN
      win_sel = ~REQ[0];
`else
      if (&REQ) win_sel = ~rr_last_q;
      else      win_sel = REQ[1];
`endif
   end

   // NOTE: synchronous reset and non-blocking assignments keep every flop updating on the same edge.
   always_ff @(posedge CLK_1M) begin
      if (RESET) begin
         state_q     <= S_INIT_WAIT;
         cnt_q       <= '0;
         idx_q       <= '0;
         init_done_q <= 1'b0;
         rr_last_q   <= 1'b1;
         rs_q        <= 1'b0;
         data_q      <= '0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         idx_q       <= idx_d;
         init_done_q <= init_done_d;
         rr_last_q   <= rr_last_d;
         rs_q        <= rs_d;
         data_q      <= data_d;
      end
   end

   always_comb begin
      // NOTE: defaults first so no path through the case leaves a signal unassigned (no latches).
      state_d     = state_q;
      cnt_d       = cnt_q;
      idx_d       = idx_q;
      init_done_d = init_done_q;
      rr_last_d   = rr_last_q;
      rs_d        = rs_q;
      data_d      = data_q;
      case (state_q)
         S_INIT_WAIT: begin
            if (cnt_q == INIT_LAST) begin
               cnt_d   = '0;
               state_d = S_INIT_SEND;
            end else cnt_d = cnt_q + 16'd1;
         end
         S_INIT_SEND: begin
            rs_d    = 1'b0;
            data_d  = init_rom(idx_q);
            state_d = S_SETUP;
         end
         S_SETUP: begin
            if (cnt_q == SETUP_LAST) begin
               cnt_d   = '0;
               state_d = S_E_HIGH;
            end else cnt_d = cnt_q + 16'd1;
         end
         S_E_HIGH: begin
            if (cnt_q == E_LAST) begin
               cnt_d   = '0;
               state_d = S_HOLD;
            end else cnt_d = cnt_q + 16'd1;
         end
         S_HOLD: begin
            if (cnt_q == hold_last) begin
               cnt_d = '0;
               if (init_done_q || idx_q == 2'd3) begin
                  init_done_d = 1'b1;
                  state_d     = S_IDLE;
               end else begin
                  // Next init byte goes straight into its setup phase.
                  idx_d   = idx_q + 2'd1;
                  rs_d    = 1'b0;
                  data_d  = init_rom(idx_d);
                  state_d = S_SETUP;
               end
            end else cnt_d = cnt_q + 16'd1;
         end
         S_IDLE: begin
            if (win_valid) begin
               rr_last_d = win_sel;
               rs_d      = REQ_RS[win_sel];
               data_d    = win_sel ? REQ_DATA1 : REQ_DATA0;
               state_d   = S_SETUP;
            end
         end
         default: state_d = S_INIT_WAIT;
      endcase
   end

   always_comb begin
      GNT = 2'b00;
      if (state_q == S_IDLE && win_valid) GNT[win_sel] = 1'b1;
      BUSY      = (state_q != S_IDLE);
      INIT_DONE = init_done_q;
      LCD_E     = (state_q == S_E_HIGH);
      LCD_RS    = rs_q;
      LCD_RW    = 1'b0;
      LCD_DATA  = data_q;
   end

endmodule

// File: tb/tb_lcd_bus_scheduler.sv
// Self-checking bench for lcd_bus_scheduler: transaction-level timing model plus literal timing pins.
module tb_lcd_bus_scheduler;

   localparam int W  = 15000;
   localparam int S  = 1;
   localparam int EH = 2;
   localparam int H  = 40;
   localparam int C  = 1600;

   typedef struct {
      int         start;
      logic       rs;
      logic [7:0] data;
      int         hold;
   } xfer_t;

   logic       clk;
   logic       RESET;
   logic [1:0] REQ;
   logic [1:0] REQ_RS;
   logic [7:0] REQ_DATA0;
   logic [7:0] REQ_DATA1;
   logic [1:0] GNT;
   logic       BUSY;
   logic       INIT_DONE;
   logic       LCD_E;
   logic       LCD_RS;
   logic       LCD_RW;
   logic [7:0] LCD_DATA;

   lcd_bus_scheduler #(
      .INIT_WAIT_CYC(W),
      .SETUP_CYC    (S),
      .E_HIGH_CYC   (EH),
      .HOLD_CYC     (H),
      .CLR_WAIT_CYC (C)
   ) dut (
      .CLK_1M   (clk),
      .RESET    (RESET),
      .REQ      (REQ),
      .REQ_RS   (REQ_RS),
      .REQ_DATA0(REQ_DATA0),
      .REQ_DATA1(REQ_DATA1),
      .GNT      (GNT),
      .BUSY     (BUSY),
      .INIT_DONE(INIT_DONE),
      .LCD_E    (LCD_E),
      .LCD_RS   (LCD_RS),
      .LCD_RW   (LCD_RW),
      .LCD_DATA (LCD_DATA)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int n_checks = 0;
   int n_fail   = 0;
   int cyc      = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         if (n_fail <= 50)
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   function automatic int hold_of(input logic rs, input logic [7:0] d);
      return (!rs && (d == 8'h01 || d == 8'h02)) ? C : H;
   endfunction

   // Model state: scheduled transfers by the cycle their setup phase begins.
   xfer_t      q[$];
   xfer_t      cur;
   bit         have_cur;
   bit         model_on = 0;
   int         idle_at;
   int         init_idle;
   logic       rr_last;
   int         first_rise;
   logic       e_prev = 1'b0;
   int         glog_cyc[$];
   logic [1:0] glog_gnt[$];
   logic [7:0] init_bytes [4] = '{8'h38, 8'h0C, 8'h06, 8'h01};

   task automatic reset_model();
      int    st;
      xfer_t x;
      q.delete();
      have_cur   = 0;
      cyc        = 0;
      rr_last    = 1'b1;
      first_rise = -1;
      st = W + 1;
      for (int k = 0; k < 4; k++) begin
         x.start = st;
         x.rs    = 1'b0;
         x.data  = init_bytes[k];
         x.hold  = hold_of(1'b0, init_bytes[k]);
         q.push_back(x);
         st += S + EH + x.hold;
      end
      idle_at   = st;
      init_idle = st;
   endtask

   always @(negedge clk) begin : compare
      logic       exp_e, exp_busy, exp_done, exp_rs, win;
      logic [7:0] exp_data;
      logic [1:0] exp_gnt;
      xfer_t      x;
      if (model_on) begin
         if (q.size() > 0 && q[0].start == cyc) begin
            cur      = q.pop_front();
            have_cur = 1;
         end
         exp_e    = have_cur && cyc >= cur.start + S && cyc < cur.start + S + EH;
         exp_rs   = have_cur ? cur.rs : 1'b0;
         exp_data = have_cur ? cur.data : 8'h00;
         exp_busy = cyc < idle_at;
         exp_done = cyc >= init_idle;
         exp_gnt  = 2'b00;
         win      = 1'b0;
         if (!exp_busy && REQ != 2'b00) begin
`ifdef LCD_FIXED_PRIO_EN
            win = ~REQ[0];
`else
            win = (REQ == 2'b11) ? ~rr_last : REQ[1];
`endif
            exp_gnt = 2'b01 << win;
         end
         check("gnt", GNT, exp_gnt);
         check("busy", BUSY, exp_busy);
         check("init_done", INIT_DONE, exp_done);
         check("lcd_e", LCD_E, exp_e);
         check("lcd_rs", LCD_RS, exp_rs);
         check("lcd_data", LCD_DATA, exp_data);
         check("lcd_rw", LCD_RW, 1'b0);
         if (LCD_E && !e_prev && first_rise < 0) first_rise = cyc;
         if (GNT != 2'b00) begin
            glog_cyc.push_back(cyc);
            glog_gnt.push_back(GNT);
         end
         if (RESET) reset_model();
         else begin
            if (exp_gnt != 2'b00) begin
               x.start = cyc + 1;
               x.rs    = REQ_RS[win];
               x.data  = win ? REQ_DATA1 : REQ_DATA0;
               x.hold  = hold_of(x.rs, x.data);
               q.push_back(x);
               idle_at = cyc + 1 + S + EH + x.hold;
               rr_last = win;
            end
            cyc++;
         end
      end else if (RESET) begin
         reset_model();
         model_on = 1;
      end
      e_prev = LCD_E;
   end

   task automatic wait_gnt(input int i, input int budget);
      bit ok = 0;
      for (int n = 0; n < budget; n++) begin
         @(negedge clk);
         if (GNT[i]) begin
            ok = 1;
            break;
         end
      end
      if (!ok) check("gnt_timeout", 0, 1);
      @(posedge clk);
      #2;
   endtask

   task automatic idle(input int n);
      repeat (n) @(posedge clk);
      #2;
   endtask

   task automatic rand_byte(output logic rs, output logic [7:0] d);
      rs = 1'($urandom_range(1));
      if ($urandom_range(15) == 0) begin
         rs = 1'b0;
         d  = ($urandom_range(1) == 0) ? 8'h01 : 8'h02;
      end else d = 8'($urandom);
   endtask

   initial begin : driver
      logic [1:0] exp3 [4];
      logic [1:0] g;
      logic       r;
      logic [7:0] d;
      int         base;
`ifdef LCD_FIXED_PRIO_EN
      exp3 = '{2'b01, 2'b01, 2'b01, 2'b01};
`else
      // Requester 0 won the previous grant, so the first tie goes to requester 1.
      exp3 = '{2'b10, 2'b01, 2'b10, 2'b01};
`endif
      RESET = 1'b1; REQ = 2'b00; REQ_RS = 2'b00; REQ_DATA0 = 8'h00; REQ_DATA1 = 8'h00;
      repeat (2) @(posedge clk);
      #2 RESET = 1'b0;

      // Init sequence, with requester 0 asking before it completes.
      idle(16000);
      REQ = 2'b01; REQ_RS = 2'b01; REQ_DATA0 = 8'h41;
      wait_gnt(0, 1000);
      REQ = 2'b00;
      check("first_e_rise", 32'(first_rise), 32'd15002);
      check("init_grant_cyc", 32'(glog_cyc[$]), 32'd16733);
      check("init_grant_val", 32'(glog_gnt[$]), 32'd1);

      // Both requesters held: alternation and 44-cycle spacing.
      idle(50);
      base = glog_cyc.size();
      REQ = 2'b11; REQ_RS = 2'b11; REQ_DATA0 = 8'h30; REQ_DATA1 = 8'h31;
      for (int n = 0; n < 400; n++) begin
         @(negedge clk);
         if (glog_cyc.size() >= base + 4) break;
      end
      @(posedge clk);
      #2 REQ = 2'b00;
      check("rr_grant_count", 32'(glog_cyc.size() >= base + 4), 32'd1);
      if (glog_cyc.size() >= base + 4) begin
         for (int k = 0; k < 4; k++) check("rr_grant_val", 32'(glog_gnt[base+k]), 32'(exp3[k]));
         for (int k = 1; k < 4; k++)
            check("rr_spacing", 32'(glog_cyc[base+k] - glog_cyc[base+k-1]), 32'd44);
      end

      // Clear display from requester 1; requester 0 waits out the long hold.
      idle(50);
      REQ = 2'b10; REQ_RS = 2'b00; REQ_DATA1 = 8'h01;
      wait_gnt(1, 100);
      REQ = 2'b00;
      idle(100);
      REQ = 2'b01; REQ_RS = 2'b01; REQ_DATA0 = 8'h42;
      wait_gnt(0, 2000);
      REQ = 2'b00;
      check("clr_spacing", 32'(glog_cyc[$] - glog_cyc[glog_cyc.size()-2]), 32'd1604);

      // Random traffic: requesters hold until granted, occasionally give up.
      for (int n = 0; n < 4000; n++) begin
         @(negedge clk);
         g = GNT;
         @(posedge clk);
         #2;
         for (int i = 0; i < 2; i++) begin
            if (g[i] || !REQ[i]) begin
               if ($urandom_range(3) == 0) begin
                  rand_byte(r, d);
                  REQ[i] = 1'b1;
                  REQ_RS[i] = r;
                  if (i == 0) REQ_DATA0 = d;
                  else        REQ_DATA1 = d;
               end else REQ[i] = 1'b0;
            end else if ($urandom_range(63) == 0) REQ[i] = 1'b0;
         end
      end
      REQ = 2'b00;

      // Reset while E is high, then re-init with a request pending throughout.
      idle(2);
      REQ = 2'b01; REQ_RS = 2'b01; REQ_DATA0 = 8'h55;
      wait_gnt(0, 2000);
      REQ = 2'b00;
      begin
         bit seen = 0;
         for (int n = 0; n < 10; n++) begin
            @(negedge clk);
            if (LCD_E) begin
               seen = 1;
               break;
            end
         end
         check("e_seen_before_reset", 32'(seen), 32'd1);
      end
      @(posedge clk);
      #2 RESET = 1'b1;
      @(posedge clk);
      #2 RESET = 1'b0;
      REQ = 2'b01; REQ_RS = 2'b00; REQ_DATA0 = 8'h80;
      wait_gnt(0, 17000);
      REQ = 2'b00;
      check("reinit_first_e_rise", 32'(first_rise), 32'd15002);
      check("reinit_grant_cyc", 32'(glog_cyc[$]), 32'd16733);
      idle(60);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
